// File: rtl/mem_arb_pkg.sv
// Shared types for mem_arbiter: FSM states, read-return owner and the return tag.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CPU_RD,
        COP_BURST,
        COP_DRAIN
    } state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_COP
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
        logic   last;
    } rd_tag_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU, coprocessor and memory-command signals of mem_arbiter; slave is the arbiter side.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 4
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              cpu_stall;

    logic              cop_req;
    logic              cop_we;
    logic [ADDR_W-1:0] cop_addr;
    logic [LEN_W-1:0]  cop_len;
    logic [DATA_W-1:0] cop_wdata;
    logic              cop_ack;
    logic [DATA_W-1:0] cop_rdata;
    logic              cop_valid;
    logic              cop_done;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cop_req, cop_we, cop_addr, cop_len, cop_wdata,
        input  mem_rdata,
        output cpu_rdata, cpu_ack, cpu_stall,
        output cop_ack, cop_rdata, cop_valid, cop_done,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cop_req, cop_we, cop_addr, cop_len, cop_wdata,
        output mem_rdata,
        input  cpu_rdata, cpu_ack, cpu_stall,
        input  cop_ack, cop_rdata, cop_valid, cop_done,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/rd_return_pipe.sv
// DEPTH-stage shift register carrying the read-return tag alongside the memory latency.
module rd_return_pipe
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t stage_q [DEPTH];

    // Reset drops every in-flight read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= tag_in;
            for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous memory between CPU load/store and coprocessor bursts, CPU first with
// a starvation override. Define MEM_ARB_STATS_EN to add the stall/beat statistic counters.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LAT     = 2,
    parameter int unsigned BURST_MAX  = 16,
    parameter int unsigned STARVE_LIM = 8
) (
    input logic clk,
    input logic rst_n,
    mem_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0] stat_cpu_stall,
    output logic [31:0] stat_cop_beats
`endif
);

    localparam int unsigned LEN_W = $clog2(BURST_MAX);
    localparam int unsigned SW    = $clog2(STARVE_LIM + 1);

    state_t            state_q, state_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [LEN_W-1:0]  left_q, left_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic              grant_cop;
    logic              cpu_ret, cop_ret;
    rd_tag_t           tag_in, tag_out;

    rd_return_pipe #(.DEPTH(RD_LAT)) u_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            starve_q <= '0;
            left_q   <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            left_q   <= left_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
        end
    end

    // Arbitration, command issue and completion; outputs held at 0 while in reset.
    always_comb begin
        state_d        = state_q;
        starve_d       = starve_q;
        left_d         = left_q;
        addr_d         = addr_q;
        we_d           = we_q;
        grant_cop      = 1'b0;
        tag_in         = '0;
        cpu_ret        = 1'b0;
        cop_ret        = 1'b0;
        bus.mem_en     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.cpu_ack    = 1'b0;
        bus.cpu_rdata  = '0;
        bus.cpu_stall  = 1'b0;
        bus.cop_ack    = 1'b0;
        bus.cop_rdata  = '0;
        bus.cop_valid  = 1'b0;
        bus.cop_done   = 1'b0;

        if (rst_n) begin
            cpu_ret = tag_out.valid && (tag_out.owner == OWN_CPU);
            cop_ret = tag_out.valid && (tag_out.owner == OWN_COP);

            case (state_q)
                IDLE: begin
                    if (bus.cop_req && (starve_q == SW'(STARVE_LIM))) begin
                        grant_cop = 1'b1;
                    end else if (bus.cpu_req) begin
                        bus.mem_en   = 1'b1;
                        bus.mem_addr = bus.cpu_addr;
                        if (bus.cpu_we) begin
                            bus.mem_we    = 1'b1;
                            bus.mem_wdata = bus.cpu_wdata;
                            bus.cpu_ack   = 1'b1;
                        end else begin
                            tag_in  = '{valid: 1'b1, owner: OWN_CPU, last: 1'b1};
                            state_d = CPU_RD;
                        end
                    end else if (bus.cop_req) begin
                        grant_cop = 1'b1;
                    end
                    if (grant_cop) begin
                        state_d = COP_BURST;
                        addr_d  = bus.cop_addr;
                        we_d    = bus.cop_we;
                        left_d  = bus.cop_len;
                    end
                end
                CPU_RD: begin
                    if (cpu_ret) begin
                        bus.cpu_ack = 1'b1;
                        state_d     = IDLE;
                    end
                end
                COP_BURST: begin
                    bus.mem_en   = 1'b1;
                    bus.mem_we   = we_q;
                    bus.mem_addr = addr_q;
                    bus.cop_ack  = 1'b1;
                    addr_d       = addr_q + ADDR_W'(1);
                    left_d       = left_q - LEN_W'(1);
                    if (we_q) begin
                        bus.mem_wdata = bus.cop_wdata;
                    end else begin
                        tag_in = '{valid: 1'b1, owner: OWN_COP, last: (left_q == '0)};
                    end
                    if (left_q == '0) begin
                        bus.cop_done = we_q;
                        state_d      = we_q ? IDLE : COP_DRAIN;
                    end
                end
                COP_DRAIN: begin
                    if (cop_ret && tag_out.last) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase

            // Read bursts complete with their last returned beat.
            if (cop_ret && tag_out.last) bus.cop_done = 1'b1;

            // Starvation counts only while the coprocessor is waiting, not while it is served.
            if (grant_cop) begin
                starve_d = '0;
            end else if (bus.cop_req && ((state_q == IDLE) || (state_q == CPU_RD))
                         && (starve_q != SW'(STARVE_LIM))) begin
                starve_d = starve_q + SW'(1);
            end

            bus.cpu_rdata = cpu_ret ? bus.mem_rdata : '0;
            bus.cop_valid = cop_ret;
            bus.cop_rdata = cop_ret ? bus.mem_rdata : '0;
            bus.cpu_stall = bus.cpu_req && !bus.cpu_ack;
        end
    end

`ifdef MEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_cpu_stall <= '0;
            stat_cop_beats <= '0;
        end else begin
            if (bus.cpu_stall) stat_cpu_stall <= stat_cpu_stall + 32'(1);
            if (bus.cop_ack)   stat_cop_beats <= stat_cop_beats + 32'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a RD_LAT=2 behavioural memory.
module tb_mem_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mem_arbiter_if #(.ADDR_W(16), .DATA_W(32), .LEN_W(4)) bus ();

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat_cpu_stall;
    logic [31:0] stat_cop_beats;
`endif

    mem_arbiter #(
        .ADDR_W(16), .DATA_W(32), .RD_LAT(2), .BURST_MAX(16), .STARVE_LIM(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_cpu_stall (stat_cpu_stall),
        .stat_cop_beats (stat_cop_beats)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: writes on the edge, read data two cycles after the command.
    logic [31:0] mem_arr [0:65535];
    logic [31:0] rd_p1, rd_p2;
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
        rd_p1 <= (bus.mem_en && !bus.mem_we) ? mem_arr[bus.mem_addr] : 32'h0;
        rd_p2 <= rd_p1;
    end
    assign bus.mem_rdata = rd_p2;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] outs;
        rst_n = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0001; bus.cpu_wdata = 32'h1;
        bus.cop_req = 1'b1; bus.cop_we = 1'b0; bus.cop_addr = 16'h0; bus.cop_len = 4'd0;
        bus.cop_wdata = 32'h0;
        #3;
        for (int c = 0; c < 2; c++) begin
            outs = {bus.mem_en, bus.mem_we, bus.cpu_ack, bus.cpu_stall,
                    bus.cop_ack, bus.cop_valid, bus.cop_done};
            checks++;
            if (outs !== 7'b0 || bus.cpu_rdata !== 32'h0 || bus.cop_rdata !== 32'h0) begin
                errors++;
                $display("FAIL reset_outputs got %b/%h/%h exp 0", outs, bus.cpu_rdata, bus.cop_rdata);
            end
            next_cycle();
        end
        bus.cpu_req = 1'b0;
        bus.cop_req = 1'b0;
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_cpu_store();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
        bus.cpu_addr = 16'h0010; bus.cpu_wdata = 32'hDEADBEEF;
        settle();
        checks++;
        if ({bus.mem_en, bus.mem_we, bus.cpu_ack, bus.cpu_stall} !== 4'b1110) begin
            errors++;
            $display("FAIL store_flags got %b exp 1110",
                     {bus.mem_en, bus.mem_we, bus.cpu_ack, bus.cpu_stall});
        end
        checks++;
        if (bus.mem_addr !== 16'h0010 || bus.mem_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL store_cmd got %h/%h exp 0010/deadbeef", bus.mem_addr, bus.mem_wdata);
        end
        next_cycle();
        bus.cpu_req = 1'b0;
        settle();
        checks++;
        if (mem_arr[16'h0010] !== 32'hDEADBEEF || bus.mem_en !== 1'b0) begin
            errors++;
            $display("FAIL store_commit got %h en %b exp deadbeef en 0", mem_arr[16'h0010], bus.mem_en);
        end
    endtask

    task automatic test_cpu_load();
        int stalls = 0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
        settle();
        checks++;
        if ({bus.mem_en, bus.mem_we, bus.cpu_ack} !== 3'b100 || bus.mem_addr !== 16'h0010) begin
            errors++;
            $display("FAIL load_issue got %b addr %h exp 100 addr 0010",
                     {bus.mem_en, bus.mem_we, bus.cpu_ack}, bus.mem_addr);
        end
        for (int k = 0; k <= 2; k++) begin
            if (bus.cpu_stall === 1'b1) stalls++;
            if (k > 0) begin
                checks++;
                if ({bus.cpu_ack, bus.mem_en} !== {(k == 2), 1'b0}) begin
                    errors++;
                    $display("FAIL load_wait_%0d got ack/en %b exp %b", k,
                             {bus.cpu_ack, bus.mem_en}, {(k == 2), 1'b0});
                end
            end
            if (k == 2) begin
                checks++;
                if (bus.cpu_rdata !== 32'hDEADBEEF) begin
                    errors++;
                    $display("FAIL load_data got %h exp deadbeef", bus.cpu_rdata);
                end
            end else begin
                next_cycle();
                settle();
            end
        end
        checks++;
        if (stalls !== 2) begin
            errors++;
            $display("FAIL load_stall_cycles got %0d exp 2", stalls);
        end
        next_cycle();
        bus.cpu_req = 1'b0;
    endtask

    task automatic test_cop_read_wrap();
        logic [31:0] exp_data [4];
        logic [15:0] ea;
        logic [2:0]  exp_flags;
        exp_data[0] = 32'hA0A0_0000; exp_data[1] = 32'hA1A1_0001;
        exp_data[2] = 32'hA2A2_0002; exp_data[3] = 32'hA3A3_0003;
        bus.cop_req = 1'b1; bus.cop_we = 1'b0; bus.cop_addr = 16'hFFFE; bus.cop_len = 4'd3;
        settle();
        checks++;
        if ({bus.mem_en, bus.cop_ack} !== 2'b00) begin
            errors++;
            $display("FAIL rd_grant_cycle got %b exp 00", {bus.mem_en, bus.cop_ack});
        end
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            settle();
            exp_flags = {(k <= 4), (k >= 3), (k == 6)};
            checks++;
            if ({bus.cop_ack, bus.cop_valid, bus.cop_done} !== exp_flags) begin
                errors++;
                $display("FAIL rd_flags_%0d got %b exp %b", k,
                         {bus.cop_ack, bus.cop_valid, bus.cop_done}, exp_flags);
            end
            if (k <= 4) begin
                ea = 16'hFFFE + 16'(k - 1);
                checks++;
                if (bus.mem_addr !== ea || bus.mem_we !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_addr_%0d got %h we %b exp %h we 0", k, bus.mem_addr, bus.mem_we, ea);
                end
            end
            if (k >= 3) begin
                checks++;
                if (bus.cop_rdata !== exp_data[k-3]) begin
                    errors++;
                    $display("FAIL rd_data_%0d got %h exp %h", k, bus.cop_rdata, exp_data[k-3]);
                end
            end
        end
        next_cycle();
        bus.cop_req = 1'b0;
        settle();
        checks++;
        if ({bus.mem_en, bus.cop_valid, bus.cop_done} !== 3'b000) begin
            errors++;
            $display("FAIL rd_after_done got %b exp 000", {bus.mem_en, bus.cop_valid, bus.cop_done});
        end
    endtask

    task automatic test_cop_write();
        bus.cop_req = 1'b1; bus.cop_we = 1'b1; bus.cop_addr = 16'h0020; bus.cop_len = 4'd1;
        settle();
        for (int k = 1; k <= 2; k++) begin
            next_cycle();
            bus.cop_wdata = (k == 1) ? 32'h1111_1111 : 32'h2222_2222;
            settle();
            checks++;
            if ({bus.cop_ack, bus.mem_we, bus.cop_done} !== {2'b11, (k == 2)}) begin
                errors++;
                $display("FAIL wr_flags_%0d got %b exp %b", k,
                         {bus.cop_ack, bus.mem_we, bus.cop_done}, {2'b11, (k == 2)});
            end
            checks++;
            if (bus.mem_addr !== 16'(16'h001F + k) || bus.mem_wdata !== bus.cop_wdata) begin
                errors++;
                $display("FAIL wr_cmd_%0d got %h/%h exp %h/%h", k, bus.mem_addr, bus.mem_wdata,
                         16'(16'h001F + k), bus.cop_wdata);
            end
        end
        next_cycle();
        bus.cop_req = 1'b0;
        settle();
        checks++;
        if (mem_arr[16'h0020] !== 32'h1111_1111 || mem_arr[16'h0021] !== 32'h2222_2222 ||
            bus.cop_ack !== 1'b0) begin
            errors++;
            $display("FAIL wr_commit got %h %h ack %b exp 11111111 22222222 ack 0",
                     mem_arr[16'h0020], mem_arr[16'h0021], bus.cop_ack);
        end
    endtask

    task automatic test_starvation();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0030; bus.cpu_wdata = 32'h0;
        bus.cop_req = 1'b1; bus.cop_we = 1'b1; bus.cop_addr = 16'h0040; bus.cop_len = 4'd0;
        bus.cop_wdata = 32'h5;
        settle();
        for (int seg = 0; seg < 2; seg++) begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if ({bus.cpu_ack, bus.cop_ack} !== 2'b10) begin
                    errors++;
                    $display("FAIL starve_cpu_%0d_%0d got %b exp 10", seg, k, {bus.cpu_ack, bus.cop_ack});
                end
                next_cycle();
                settle();
            end
            checks++;
            if ({bus.cpu_ack, bus.mem_en, bus.cop_ack} !== 3'b000) begin
                errors++;
                $display("FAIL starve_grant_%0d got %b exp 000", seg,
                         {bus.cpu_ack, bus.mem_en, bus.cop_ack});
            end
            next_cycle();
            settle();
            checks++;
            if ({bus.cpu_ack, bus.cop_ack, bus.cop_done, bus.cpu_stall} !== 4'b0111) begin
                errors++;
                $display("FAIL starve_beat_%0d got %b exp 0111", seg,
                         {bus.cpu_ack, bus.cop_ack, bus.cop_done, bus.cpu_stall});
            end
            next_cycle();
            settle();
        end
        checks++;
        if (bus.cpu_ack !== 1'b1) begin
            errors++;
            $display("FAIL starve_cleared got %b exp 1", bus.cpu_ack);
        end
        bus.cpu_req = 1'b0;
        bus.cop_req = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_mid_burst();
        logic [2:0] exp_flags;
        bus.cop_req = 1'b1; bus.cop_we = 1'b0; bus.cop_addr = 16'hFFFE; bus.cop_len = 4'd3;
        settle();
        next_cycle();
        next_cycle();
        settle();
        checks++;
        if (bus.cop_ack !== 1'b1 || bus.mem_addr !== 16'hFFFF) begin
            errors++;
            $display("FAIL rst_burst_beat2 got ack %b addr %h exp 1 ffff", bus.cop_ack, bus.mem_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.mem_en, bus.cop_ack, bus.cop_valid, bus.cop_done, bus.cpu_ack} !== 5'b0) begin
            errors++;
            $display("FAIL rst_immediate got %b exp 00000",
                     {bus.mem_en, bus.cop_ack, bus.cop_valid, bus.cop_done, bus.cpu_ack});
        end
        bus.cop_req = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            settle();
            checks++;
            if ({bus.cop_valid, bus.cop_done, bus.mem_en} !== 3'b000) begin
                errors++;
                $display("FAIL rst_flushed_%0d got %b exp 000", k,
                         {bus.cop_valid, bus.cop_done, bus.mem_en});
            end
        end
        bus.cop_req = 1'b1; bus.cop_we = 1'b0; bus.cop_addr = 16'h0010; bus.cop_len = 4'd0;
        settle();
        for (int k = 1; k <= 3; k++) begin
            next_cycle();
            settle();
            exp_flags = {(k == 1), (k == 3), (k == 3)};
            checks++;
            if ({bus.cop_ack, bus.cop_valid, bus.cop_done} !== exp_flags) begin
                errors++;
                $display("FAIL rst_fresh_%0d got %b exp %b", k,
                         {bus.cop_ack, bus.cop_valid, bus.cop_done}, exp_flags);
            end
        end
        checks++;
        if (bus.cop_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rst_fresh_data got %h exp deadbeef", bus.cop_rdata);
        end
        next_cycle();
        bus.cop_req = 1'b0;
    endtask

`ifdef MEM_ARB_STATS_EN
    task automatic test_stats();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        settle();
        checks++;
        if (stat_cpu_stall !== 32'd0 || stat_cop_beats !== 32'd0) begin
            errors++;
            $display("FAIL stats_reset got %0d/%0d exp 0/0", stat_cpu_stall, stat_cop_beats);
        end
        bus.cop_req = 1'b1; bus.cop_we = 1'b0; bus.cop_addr = 16'h0000; bus.cop_len = 4'd3;
        next_cycle();
        next_cycle();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0050; bus.cpu_wdata = 32'h9;
        repeat (4) next_cycle();
        settle();
        checks++;
        if (bus.cop_done !== 1'b1) begin
            errors++;
            $display("FAIL stats_burst_done got %b exp 1", bus.cop_done);
        end
        next_cycle();
        bus.cop_req = 1'b0;
        settle();
        checks++;
        if (bus.cpu_ack !== 1'b1) begin
            errors++;
            $display("FAIL stats_cpu_ack got %b exp 1", bus.cpu_ack);
        end
        next_cycle();
        bus.cpu_req = 1'b0;
        settle();
        checks++;
        if (stat_cpu_stall !== 32'd5 || stat_cop_beats !== 32'd4) begin
            errors++;
            $display("FAIL stats_counts got %0d/%0d exp 5/4", stat_cpu_stall, stat_cop_beats);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        mem_arr[16'hFFFE] = 32'hA0A0_0000;
        mem_arr[16'hFFFF] = 32'hA1A1_0001;
        mem_arr[16'h0000] = 32'hA2A2_0002;
        mem_arr[16'h0001] = 32'hA3A3_0003;
        mem_arr[16'h0002] = 32'h0;
        mem_arr[16'h0003] = 32'h0;
        test_reset();
        test_cpu_store();
        test_cpu_load();
        test_cop_read_wrap();
        test_cop_write();
        test_starvation();
        test_reset_mid_burst();
`ifdef MEM_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates one shared single-port synchronous data memory between the CPU load/store path and the image coprocessor's burst DMA port. CPU requests come from the decoded `mem_en` / `mem_rd_wr` path. Coprocessor transfers are multi-beat bursts. CPU has priority, and a starvation counter bounds coprocessor wait time.

## Interface
- `ADDR_W`, 16, word address width
- `DATA_W`, 32, data width
- `RD_LAT`, 2, memory read latency in cycles (legal 1..7)
- `BURST_MAX`, 16, maximum coprocessor beats per burst (power of 2)
- `STARVE_LIM`, 8, denied cycles before the coprocessor overrides CPU priority
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `cpu_req`  in  1  CPU access request, held until `cpu_ack`
- `cpu_we`  in  1  1 = store, 0 = load
- `cpu_addr`  in  ADDR_W  CPU word address
- `cpu_wdata`  in  DATA_W  store data
- `cpu_rdata`  out  DATA_W  load data, valid with `cpu_ack` on a load
- `cpu_ack`  out  1  access complete
- `cpu_stall`  out  1  `cpu_req & ~cpu_ack`
- `cop_req`  in  1  burst request, held until `cop_done`
- `cop_we`  in  1  burst direction
- `cop_addr`  in  ADDR_W  burst start address
- `cop_len`  in  clog2(BURST_MAX)  beats minus 1
- `cop_wdata`  in  DATA_W  write beat data, consumed when `cop_ack`
- `cop_ack`  out  1  beat issued to memory this cycle
- `cop_rdata`  out  DATA_W  read beat data
- `cop_valid`  out  1  `cop_rdata` valid
- `cop_done`  out  1  one-cycle pulse: burst complete
- `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`  out  1/1/ADDR_W/DATA_W  memory command
- `mem_rdata`  in  DATA_W  memory read data, RD_LAT cycles after read command

## Operation
- States: IDLE, CPU_RD, COP_BURST, COP_DRAIN.
- Arbitration happens in IDLE only:
  - Grant goes to the coprocessor if `cop_req` is high and the starve count equals STARVE_LIM.
  - Otherwise grant goes to the CPU if `cpu_req` is high.
  - Otherwise grant goes to the coprocessor if `cop_req` is high.
- Starve counter:
  - Increments each cycle `cop_req` is high and the coprocessor is not granted; saturates at STARVE_LIM.
  - Clears on coprocessor grant.
- CPU store in IDLE: `mem_en=1`, `mem_we=1`, `cpu_ack=1` in the same cycle. State stays IDLE.
- CPU load in IDLE: read is issued and the block goes to CPU_RD. `cpu_ack` and `cpu_rdata` are asserted RD_LAT cycles after issue, then the block returns to IDLE. No other command issues while in CPU_RD.
- Coprocessor grant in IDLE:
  - Latch `cop_we`, `cop_addr`, and beat count `cop_len+1`, then go to COP_BURST. No memory command issues in the grant cycle.
  - COP_BURST issues one beat per cycle, with `cop_ack=1` on each. The address increments by 1 per beat, modulo 2^ADDR_W.
  - Write bursts: `cop_done` is asserted with the last beat, then IDLE.
  - Read bursts: go to COP_DRAIN after the last issue. `cop_done` is asserted together with the last `cop_valid`, then IDLE.
- Read return path: an RD_LAT-deep tagged pipeline carrying {valid, owner, last}. `cpu_rdata` and `cop_rdata` are `mem_rdata` passed through. Valid/ack signals come from the pipeline tag.
- `cpu_req` arriving during a coprocessor burst waits. Worst-case CPU wait is BURST_MAX+RD_LAT+1 cycles.
- A coprocessor with `cop_req` still high after `cop_done` is treated as a new burst, arbitrated in the next IDLE cycle.

## Timing
- Reset (async, any state): state=IDLE, starve count=0, pipeline flushed (in-flight reads dropped), all outputs 0.
- After reset deasserts: first arbitration on the first rising edge.
- `mem_*`, `cpu_ack`, and `cop_ack` are combinational from state and inputs. Pipeline and state are registered.
- CPU store: latency 0. CPU load: latency RD_LAT from the issue cycle.
- Coprocessor burst granted in cycle N with L = `cop_len`:
  - Beats issue in cycles N+1..N+L+1.
  - Write burst: `cop_done` at N+L+1.
  - Read burst: `cop_valid` at N+1+RD_LAT..N+L+1+RD_LAT, and `cop_done` at N+L+1+RD_LAT.
- Simultaneous `cpu_req` and `cop_req` in IDLE below STARVE_LIM: CPU wins, and the starve count increments.
- `cop_len=0`: single beat.
- Address wrap from 2^ADDR_W-1 to 0 is legal and silent.

## Configuration
- `MEM_ARB_STATS_EN` defined: adds outputs `stat_cpu_stall` and `stat_cop_beats` (32-bit, free-running, wrapping, cleared by reset).
  - `stat_cpu_stall` increments on each cycle with `cpu_stall`.
  - `stat_cop_beats` increments on each `cop_ack`.
- Undefined: those ports and counters are absent. All other behaviour is identical.

## Structure
- Package `mem_arb_pkg`: state enum (IDLE, CPU_RD, COP_BURST, COP_DRAIN), owner enum (OWN_CPU, OWN_COP), and the return-tag struct {valid, owner, last}.
- Sub-module `rd_return_pipe`: parameterised RD_LAT-stage tag shift register with async reset.

## Test plan
- CPU store to addr 0x0010, data 0xDEADBEEF, in IDLE -> `mem_en`, `mem_we`, `cpu_ack` all high in the same cycle; `cpu_stall=0`.
- CPU load from 0x0010 with RD_LAT=2 -> `cpu_ack` 2 cycles after issue with `cpu_rdata=0xDEADBEEF`; `cpu_stall` high for exactly 2 cycles.
- Coprocessor read burst at 0xFFFE with `cop_len=3` -> addresses FFFE, FFFF, 0000, 0001; four `cop_valid` pulses; `cop_done` on the 4th pulse.
- `cpu_req` and `cop_req` held continuously -> CPU is granted until the starve count reaches 8, then the coprocessor is granted; the starve count returns to 0.
- `rst_n` low mid read-burst (beat 2 of 4) -> all outputs 0 immediately, no further `cop_valid`; after release, an IDLE arbitration grants a fresh request.
- `MEM_ARB_STATS_EN` build: 5 CPU stall cycles plus one 4-beat burst -> `stat_cpu_stall=5`, `stat_cop_beats=4`.
